bus_arbiter_rr4: RTL

//  Round-robin arbiter sharing one 32-bit datapath resource between four requesters.

---
 rtl/bus_arbiter_rr4_pkg.sv | 27 ++
 rtl/bus_arbiter_rr4_if.sv | 34 +++
 rtl/bus_arbiter_rr4_pick.sv | 33 +++
 rtl/bus_arbiter_rr4.sv | 149 ++++++++++++++
 4 files changed

// File: rtl/bus_arbiter_rr4_pkg.sv
// Purpose: shared definitions for the four-requester round-robin bus arbiter:
//          requester count, select width, FSM state encoding and small index
//          helpers used by the arbiter top, the picker and the bus interface.
// Ports:   none (package).
package arb_defs;

  localparam int unsigned NREQ  = 4;
  localparam int unsigned SEL_W = 2;

  typedef logic [NREQ-1:0]  req_vec_t;
  typedef logic [SEL_W-1:0] idx_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } arb_state_t;

  // Next requester index; the 2-bit width gives the 3 -> 0 wrap for free.
  function automatic idx_t idx_inc(input idx_t i);
    return i + idx_t'(1);
  endfunction

  function automatic req_vec_t idx_onehot(input idx_t i);
    return req_vec_t'(1) << i;
  endfunction

endpackage

// File: rtl/bus_arbiter_rr4_if.sv
// Purpose: request/grant/handshake bundle between four requesters, the shared
//          target and the round-robin arbiter.
// Signals: req[4]      per-requester request, level, held until acknowledged
//          lock[4]     owner keeps the bus for its next transfer
//          ack         target accepted the current transfer
//          gnt[4]      one-hot grant, zero when idle
//          sel[2]      downstream data mux select (current/last owner)
//          valid       shared bus transfer valid
//          timeout_err one-cycle pulse on watchdog abort
//          err_id[2]   owner captured at the last abort
// Modports: master = arbiter side, slave = requesters/target side.
interface bus_arbiter_rr4_if;
  import arb_defs::*;

  req_vec_t req;
  req_vec_t lock;
  logic     ack;
  req_vec_t gnt;
  idx_t     sel;
  logic     valid;
  logic     timeout_err;
  idx_t     err_id;

  modport master (
    input  req, lock, ack,
    output gnt, sel, valid, timeout_err, err_id
  );

  modport slave (
    output req, lock, ack,
    input  gnt, sel, valid, timeout_err, err_id
  );

endinterface

// File: rtl/bus_arbiter_rr4_pick.sv
// Purpose: combinational round-robin picker. Returns the first set request
//          bit scanning ptr, ptr+1, ... modulo four.
// Ports:   req[4] in  request vector
//          ptr[2] in  index holding top priority
//          hit    out at least one request set
//          idx[2] out winning requester (equals ptr when no hit)
module rr_pick4
  import arb_defs::*;
(
  input  req_vec_t req,
  input  idx_t     ptr,
  output logic     hit,
  output idx_t     idx
);

  idx_t cand;

  // Scan from the lowest priority upwards so the last assignment made is the
  // highest-priority hit; avoids a separate "found" flag.
  always_comb begin
    hit  = 1'b0;
    idx  = ptr;
    cand = ptr;
    for (int unsigned j = 0; j < NREQ; j++) begin
      cand = ptr + idx_t'(NREQ - 1 - j);
      if (req[cand]) begin
        hit = 1'b1;
        idx = cand;
      end
    end
  end

endmodule

// File: rtl/bus_arbiter_rr4.sv
// Purpose: round-robin arbiter sharing one 32-bit datapath between four
//          requesters. Drives the downstream mux select and the valid/ack
//          handshake to the target, supports per-requester bus lock and
//          aborts grants the target never acknowledges.
// Ports:   clk   in  clock, all state on rising edge
//          rst_n in  asynchronous active-low reset
//          bus   master modport of bus_arbiter_rr4_if (req, lock, ack in;
//                gnt, sel, valid, timeout_err, err_id out; all registered)
// Params:  TIMEOUT_CYCLES busy cycles without ack before abort (1..2**CNT_W-1)
//          CNT_W          watchdog counter width
//          RESET_PTR      requester holding top priority after reset (0..3)
module bus_arbiter_rr4
  import arb_defs::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 15,
  parameter int unsigned CNT_W          = 4,
  parameter int unsigned RESET_PTR      = 0
) (
  input  logic               clk,
  input  logic               rst_n,
  bus_arbiter_rr4_if.master  bus
);

  arb_state_t       state_q, state_d;
  idx_t             ptr_q,   ptr_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;
  req_vec_t         gnt_q,   gnt_d;
  idx_t             sel_q,   sel_d;
  logic             valid_q, valid_d;
  logic             terr_q,  terr_d;
  idx_t             errid_q, errid_d;

  idx_t scan_ptr;
  logic pick_hit;
  idx_t pick_idx;
  logic own_req;
  logic own_lock;

  // sel_q doubles as the current owner while busy.
  assign own_req  = bus.req[sel_q];
  assign own_lock = bus.lock[sel_q];

  // While busy the only pick that matters is the hand-over on ack, which
  // starts scanning just past the owner; the owner therefore comes last and
  // is re-picked only when it is the sole requester.
  assign scan_ptr = (state_q == ST_BUSY) ? idx_inc(sel_q) : ptr_q;

  rr_pick4 u_pick (
    .req (bus.req),
    .ptr (scan_ptr),
    .hit (pick_hit),
    .idx (pick_idx)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      ptr_q   <= idx_t'(RESET_PTR);
      cnt_q   <= '0;
      gnt_q   <= '0;
      sel_q   <= '0;
      valid_q <= 1'b0;
      terr_q  <= 1'b0;
      errid_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      gnt_q   <= gnt_d;
      sel_q   <= sel_d;
      valid_q <= valid_d;
      terr_q  <= terr_d;
      errid_q <= errid_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    gnt_d   = gnt_q;
    sel_d   = sel_q;
    valid_d = valid_q;
    terr_d  = 1'b0;
    errid_d = errid_q;

    unique case (state_q)
      ST_IDLE: begin
        // ack while idle is ignored; sel keeps the last owner.
        if (pick_hit) begin
          state_d = ST_BUSY;
          sel_d   = pick_idx;
          gnt_d   = idx_onehot(pick_idx);
          valid_d = 1'b1;
          cnt_d   = '0;
        end
      end

      ST_BUSY: begin
        if (bus.ack) begin
          // ack takes precedence over a watchdog expiry in the same cycle.
          cnt_d = '0;
          if (!(own_lock && own_req)) begin
            ptr_d = idx_inc(sel_q);
            if (pick_hit) begin
              sel_d = pick_idx;
              gnt_d = idx_onehot(pick_idx);
            end else begin
              state_d = ST_IDLE;
              gnt_d   = '0;
              valid_d = 1'b0;
            end
          end
        end else if (!own_req) begin
          ptr_d   = idx_inc(sel_q);
          state_d = ST_IDLE;
          gnt_d   = '0;
          valid_d = 1'b0;
          cnt_d   = '0;
        end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          // This busy cycle is the TIMEOUT_CYCLES-th without ack. Dropping
          // to IDLE yields the idle cycle before any regrant.
          ptr_d   = idx_inc(sel_q);
          state_d = ST_IDLE;
          gnt_d   = '0;
          valid_d = 1'b0;
          cnt_d   = '0;
          terr_d  = 1'b1;
          errid_d = sel_q;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      default: begin
        state_d = ST_IDLE;
        gnt_d   = '0;
        valid_d = 1'b0;
      end
    endcase
  end

  assign bus.gnt         = gnt_q;
  assign bus.sel         = sel_q;
  assign bus.valid       = valid_q;
  assign bus.timeout_err = terr_q;
  assign bus.err_id      = errid_q;

endmodule
